// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window generator: window tap indices,
// default image geometry and a counter-width helper.
package sobel_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_DATA_W     = 8;

  // Row-major tap positions inside the 3x3 window
  localparam int W_TL = 0;
  localparam int W_TC = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MC = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BC = 7;
  localparam int W_BR = 8;

  function automatic int ctr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel storage: asynchronous read and synchronous write at a
// shared address, so the old value is read in the same cycle it is replaced.
module sobel_line_buf #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-order 3x3 window generator for a Sobel stage, interior centres only.
// Optional macro SOBEL_WIN_COORD_EN adds win_row/win_col centre outputs.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [9*DATA_W-1:0]   win_out,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  frame_done
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [15:0]           win_row,
  output logic [15:0]           win_col
`endif
);

  localparam int CW = ctr_w(IMG_WIDTH);
  localparam int RW = ctr_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              accept;
  logic              win_hit;
  logic [DATA_W-1:0] line0_rd;
  logic [DATA_W-1:0] line1_rd;
  logic [DATA_W-1:0] win_p1 [3][3];

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign win_hit   = (row >= ROW_MIN) && (col >= COL_MIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // line0 holds the previous line, line1 the one before it
  sobel_line_buf #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_line0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (pix_in),
    .rdata (line0_rd)
  );

  sobel_line_buf #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_line1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (line0_rd),
    .rdata (line1_rd)
  );

  // ---- stage p1: window shift register, valid and frame pulse ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_p1[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_p1[r][0] <= win_p1[r][1];
        win_p1[r][1] <= win_p1[r][2];
      end
      win_p1[0][2] <= line1_rd;
      win_p1[1][2] <= line0_rd;
      win_p1[2][2] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && (row == ROW_LAST) && (col == COL_LAST);
      if (accept)         win_valid <= win_hit;
      else if (win_ready) win_valid <= 1'b0;
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      win_row <= '0;
      win_col <= '0;
    end else if (accept && win_hit) begin
      win_row <= 16'(row) - 16'd1;
      win_col <= 16'(col) - 16'd1;
    end
  end
`endif

  assign win_out[DATA_W*W_TL +: DATA_W] = win_p1[0][0];
  assign win_out[DATA_W*W_TC +: DATA_W] = win_p1[0][1];
  assign win_out[DATA_W*W_TR +: DATA_W] = win_p1[0][2];
  assign win_out[DATA_W*W_ML +: DATA_W] = win_p1[1][0];
  assign win_out[DATA_W*W_MC +: DATA_W] = win_p1[1][1];
  assign win_out[DATA_W*W_MR +: DATA_W] = win_p1[1][2];
  assign win_out[DATA_W*W_BL +: DATA_W] = win_p1[2][0];
  assign win_out[DATA_W*W_BC +: DATA_W] = win_p1[2][1];
  assign win_out[DATA_W*W_BR +: DATA_W] = win_p1[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 frame with pixel = 10*row + col.
module tb_sobel_window_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [9*DW-1:0] win_out;
  logic          win_valid;
  logic          win_ready;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  logic [9*DW-1:0] got_q[$];

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  // Handshakes are judged at the falling edge, half a cycle before they complete
  always @(negedge clk) begin
    if (win_valid && win_ready) got_q.push_back(win_out);
    if (frame_done) fd_cnt++;
  end

  function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
    logic [9*DW-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++)
      v[DW*k +: DW] = DW'(10 * (r - 1 + k / 3) + (c - 1 + k % 3));
    return v;
  endfunction

  task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_pix(input int idx, input bit gaps);
    int t;
    pix_in = DW'(10 * (idx / W) + idx % W);
    if (gaps) begin
      while ($urandom_range(1) == 0) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix_valid = 1'b1;
    t = 0;
    while (!pix_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $error("FAIL ready_timeout: observed pix_ready=0 for %0d cycles, expected 1", t);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_pixels(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) send_pix(i, gaps);
  endtask

  task automatic check_frames(input string tag, input int nfr);
    int f;
    repeat (2) @(negedge clk);
    check({tag, "_count"}, 72'(got_q.size()), 72'(6 * nfr));
    for (int i = 0; i < 6 * nfr; i++) begin
      if (i < got_q.size()) begin
        f = i % 6;
        check($sformatf("%s_win%0d", tag, i), got_q[i], exp_win(1 + f / 3, 1 + f % 3));
      end
    end
    check({tag, "_frame_done_cnt"}, 72'(fd_cnt), 72'(nfr));
  endtask

  initial begin
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_in    = '0;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_win_valid", 72'(win_valid), 72'd0);
    check("rst_frame_done", 72'(frame_done), 72'd0);
    check("rst_win_out", win_out, 72'd0);
    check("rst_pix_ready", 72'(pix_ready), 72'd1);
    reset = 1'b0;

    // Two back-to-back frames, no gaps, downstream always ready
    got_q.delete();
    fd_cnt = 0;
    send_pixels(0, 11, 1'b0);
    check("pre_first_valid", 72'(win_valid), 72'd0);
    send_pix(12, 1'b0);
    check("first_valid", 72'(win_valid), 72'd1);
    check("first_win", win_out, exp_win(1, 1));
    send_pixels(13, 19, 1'b0);
    check("last_win", win_out, exp_win(2, 3));
    check("fd_pulse", 72'(frame_done), 72'd1);
    send_pix(0, 1'b0);
    check("fd_one_cycle", 72'(frame_done), 72'd0);
    send_pixels(1, 19, 1'b0);
    check_frames("b2b", 2);

    // Random 50% pix_valid
    got_q.delete();
    fd_cnt = 0;
    send_pixels(0, 19, 1'b1);
    check_frames("gaps", 1);

    // Downstream stall on the first window
    got_q.delete();
    fd_cnt = 0;
    send_pixels(0, 12, 1'b0);
    win_ready = 1'b0;
    #1;
    check("stall_ready_low", 72'(pix_ready), 72'd0);
    pix_in    = DW'(23);
    pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall_win_%0d", i), win_out, exp_win(1, 1));
      check($sformatf("stall_valid_%0d", i), 72'(win_valid), 72'd1);
      check($sformatf("stall_pix_ready_%0d", i), 72'(pix_ready), 72'd0);
    end
    win_ready = 1'b1;
    #1;
    check("unstall_ready", 72'(pix_ready), 72'd1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    check("after_stall_win", win_out, exp_win(1, 2));
    send_pixels(14, 19, 1'b0);
    check_frames("stall", 1);

    // Reset mid-frame with a window pending
    got_q.delete();
    send_pixels(0, 13, 1'b0);
    win_ready = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_win_valid", 72'(win_valid), 72'd0);
    check("midrst_win_out", win_out, 72'd0);
    check("midrst_frame_done", 72'(frame_done), 72'd0);
    got_q.delete();
    fd_cnt = 0;
    win_ready = 1'b1;
    send_pixels(0, 19, 1'b0);
    check_frames("midrst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line, legal range 3..4096.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame, legal range 3..4096.
REQ-003 SHALL have parameter DATA_W, default 8, grayscale pixel width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pix_in, input, DATA_W bits: grayscale pixel, raster order.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in holds a valid pixel.
REQ-008 SHALL have port pix_ready, output, 1 bit: the block can accept a pixel.
REQ-009 SHALL have port win_out, output, 9*DATA_W bits: 3x3 window, w[k] at bits [DATA_W*k +: DATA_W], k=0 top-left, row-major, k=8 bottom-right.
REQ-010 SHALL have port win_valid, output, 1 bit: win_out holds a valid window.
REQ-011 SHALL have port win_ready, input, 1 bit: the downstream Sobel stage accepts the window.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-013 SHALL accept a pixel only on a cycle where pix_valid && pix_ready is true.
REQ-014 SHALL drive pix_ready = !win_valid || win_ready, combinationally.
REQ-015 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), both advancing only on an accepted pixel.
REQ-016 SHALL wrap col to 0 at IMG_WIDTH-1 and increment row; at row=IMG_HEIGHT-1 with col=IMG_WIDTH-1, both counters SHALL wrap to 0.
REQ-017 SHALL store the two previous lines in two line buffers of IMG_WIDTH x DATA_W each; on an accepted pixel, line1[col] SHALL take line0[col] and line0[col] SHALL take pix_in.
REQ-018 SHALL keep a 3x3 shift register with three columns; each accepted pixel SHALL shift in the column {line1[col], line0[col], pix_in} (top to bottom).
REQ-019 SHALL set win_valid on the cycle after accepting pixel (row, col) with row>=2 and col>=2; the window is then centred on (row-1, col-1).
REQ-020 SHALL emit no windows for border centres (row 0, row H-1, col 0, col W-1): exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.
REQ-021 SHALL hold win_out and win_valid stable while win_valid && !win_ready.
REQ-022 SHALL clear win_valid when win_ready is high and no new qualifying pixel is accepted in the same cycle; accept-and-emit in one cycle SHALL sustain 1 window/cycle.
REQ-023 SHALL pulse frame_done high for exactly one cycle, the cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-024 SHALL ignore pix_in when pix_valid is low; counters and buffers SHALL hold.

Reset
REQ-025 SHALL, on reset, set col=0, row=0, win_valid=0, frame_done=0, and win_out=0.
REQ-026 SHALL NOT clear line-buffer contents on reset; stale data is never emitted (REQ-019).
REQ-027 SHALL, on reset mid-frame, drop any pending window and start a fresh frame with the next accepted pixel.

Configuration
REQ-028 SHALL, when macro SOBEL_WIN_COORD_EN is defined, add outputs win_row and win_col (16 bits each), giving the window centre coordinates, registered with win_out and reset to 0.
REQ-029 SHALL, when SOBEL_WIN_COORD_EN is undefined, omit these ports and their logic; other behaviour is identical.

Structure
REQ-030 SHALL take the window index constants (W_TL=0 .. W_BR=8) and the default dimensions from shared package sobel_pkg.
REQ-031 SHALL implement each line buffer as sub-module sobel_line_buf (parameters DEPTH, DATA_W; one write port and one read port at the same address), instantiated twice.

Verification
REQ-032 SHALL cover: W=5, H=4, pix=10*r+c, win_ready=1 -> first window one cycle after pixel (2,2), win_out = {0,1,2,10,11,12,20,21,22} (w0..w8).
REQ-033 SHALL cover: same frame -> exactly 6 windows, the last centred on (2,3) = {12,13,14,22,23,24,32,33,34}, with frame_done pulsing once after pixel (3,4).
REQ-034 SHALL cover: win_ready held low for 3 cycles on the first window -> win_out stable, pix_ready=0, no pixel lost, and the next window is {1,2,3,11,12,13,21,22,23}.
REQ-035 SHALL cover: pix_valid toggled randomly at 50% -> window sequence identical to REQ-032/033.
REQ-036 SHALL cover: reset asserted after pixel (2,3), then a new full frame -> first window again {0,1,2,10,11,12,20,21,22} and 6 windows total.
REQ-037 SHALL cover: two back-to-back frames -> counters wrap and the second frame emits identical windows with no cross-frame mixing.
